// File: rtl/id_issue_ctrl.sv
// ID-stage issue control for the dual-slot IF_ID queue: picks 2/1/0 launches per cycle
// under load-use scoreboard, pairing rules and a serialising-instruction FSM.

module id_sb_cnt #(
    parameter logic [1:0] LAT = 2'd2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic set,
    output logic busy
);
    logic [1:0] cnt;

    // A fresh load overrides the running decrement on the same register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             cnt <= '0;
        else if (clr)        cnt <= '0;
        else if (set)        cnt <= LAT;
        else if (cnt != '0)  cnt <= cnt - 2'd1;
    end

    assign busy = |cnt;
endmodule

module id_issue_ctrl #(
    parameter int DUAL_EN  = 1,
    parameter int LOAD_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       line1_valid_i,
    input  logic       line2_valid_i,
    input  logic [4:0] line1_rd_i,
    input  logic [4:0] line2_rd_i,
    input  logic       line1_rd_we_i,
    input  logic       line2_rd_we_i,
    input  logic [4:0] line1_rj_i,
    input  logic [4:0] line2_rj_i,
    input  logic [4:0] line1_rk_i,
    input  logic [4:0] line2_rk_i,
    input  logic       line1_rj_re_i,
    input  logic       line2_rj_re_i,
    input  logic       line1_rk_re_i,
    input  logic       line2_rk_re_i,
    input  logic       line1_is_load_i,
    input  logic       line2_is_load_i,
    input  logic       line1_is_serial_i,
    input  logic       line2_is_serial_i,
    input  logic       line1_is_branch_i,
    input  logic       line2_is_branch_i,
    input  logic       line1_is_muldiv_i,
    input  logic       line2_is_muldiv_i,
    input  logic       exe_allowin_i,
    input  logic       pipe_empty_i,
    input  logic       serial_done_i,
    input  logic       branch_flush_i,
    input  logic       excep_flush_i,
    output logic       double_valid_inst_lunch_flag_o,
    output logic       single_valid_inst_lunch_flag_o,
    output logic       zero_valid_inst_lunch_flag_o,
    output logic       line1_launch_valid_o,
    output logic       line2_launch_valid_o,
    output logic       serial_busy_o
);
    localparam logic [1:0] LAT = LOAD_LAT[1:0];

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       rd_we;
        logic [4:0] rj;
        logic       rj_re;
        logic [4:0] rk;
        logic       rk_re;
        logic       is_load;
        logic       is_serial;
        logic       is_branch;
        logic       is_muldiv;
    } line_t;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        DRAIN  = 2'd1,
        SERIAL = 2'd2
    } state_t;

    line_t [1:0] ln;
    state_t      state, state_nxt;
    logic [31:0] busy;
    logic [1:0]  haz, launch, ld_wr;
    logic        flush, l1_pre, fsm_ok, raw, waw, pair_ok;
    logic        unused_br2;

    assign ln[0] = '{line1_valid_i, line1_rd_i, line1_rd_we_i, line1_rj_i, line1_rj_re_i,
                     line1_rk_i, line1_rk_re_i, line1_is_load_i, line1_is_serial_i,
                     line1_is_branch_i, line1_is_muldiv_i};
    assign ln[1] = '{line2_valid_i, line2_rd_i, line2_rd_we_i, line2_rj_i, line2_rj_re_i,
                     line2_rk_i, line2_rk_re_i, line2_is_load_i, line2_is_serial_i,
                     line2_is_branch_i, line2_is_muldiv_i};

    // A branch in line2 is harmless: it is the younger slot and nothing follows it.
    assign unused_br2 = ln[1].is_branch;

    assign flush = rst | branch_flush_i | excep_flush_i;

    // r0 never busy, so indexing busy[] covers the nonzero-register check too.
    assign busy[0] = 1'b0;
    generate
        for (genvar r = 1; r < 32; r++) begin : g_sb
            id_sb_cnt #(.LAT(LAT)) u_cnt (
                .clk  (clk),
                .rst  (rst),
                .clr  (flush),
                .set  ((ld_wr[0] && ln[0].rd == r[4:0]) || (ld_wr[1] && ln[1].rd == r[4:0])),
                .busy (busy[r])
            );
        end
        for (genvar k = 0; k < 2; k++) begin : g_lane
            assign haz[k]   = (ln[k].rj_re & busy[ln[k].rj]) | (ln[k].rk_re & busy[ln[k].rk]);
            assign ld_wr[k] = launch[k] & ln[k].is_load & ln[k].rd_we & (ln[k].rd != 5'd0);
        end
    endgenerate

    always_comb begin
        fsm_ok = 1'b0;
        case (state)
            NORMAL:  fsm_ok = ~ln[0].is_serial | pipe_empty_i;
            DRAIN:   fsm_ok = pipe_empty_i;
            default: fsm_ok = 1'b0;
        endcase
    end

    assign l1_pre    = ln[0].valid & exe_allowin_i & ~flush & ~haz[0];
    assign launch[0] = l1_pre & fsm_ok;

    assign raw = ln[0].rd_we && ln[0].rd != 5'd0 &&
                 ((ln[1].rj_re && ln[1].rj == ln[0].rd) || (ln[1].rk_re && ln[1].rk == ln[0].rd));
    assign waw = ln[0].rd_we && ln[1].rd_we && ln[0].rd == ln[1].rd && ln[0].rd != 5'd0;

    assign pair_ok = (DUAL_EN != 0) & ln[1].valid & ~ln[0].is_serial & ~ln[1].is_serial &
                     ~ln[0].is_branch & ~(ln[0].is_muldiv & ln[1].is_muldiv) &
                     ~(ln[0].is_load & ln[1].is_load) & ~haz[1] & ~raw & ~waw;

    assign launch[1] = launch[0] & pair_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= NORMAL;
        else     state <= state_nxt;
    end

    // DRAIN only when the sole obstacle for a serial line1 is a non-empty pipe.
    always_comb begin
        state_nxt = state;
        case (state)
            NORMAL: begin
                if (launch[0] & ln[0].is_serial)
                    state_nxt = SERIAL;
                else if (l1_pre & ln[0].is_serial & ~pipe_empty_i)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (launch[0])
                    state_nxt = ln[0].is_serial ? SERIAL : NORMAL;
            end
            SERIAL: begin
                if (serial_done_i)
                    state_nxt = NORMAL;
            end
            default: state_nxt = NORMAL;
        endcase
        if (flush)
            state_nxt = NORMAL;
    end

    assign double_valid_inst_lunch_flag_o = launch[0] & launch[1];
    assign single_valid_inst_lunch_flag_o = launch[0] & ~launch[1];
    assign zero_valid_inst_lunch_flag_o   = ~launch[0];
    assign line1_launch_valid_o           = launch[0];
    assign line2_launch_valid_o           = launch[1];
    assign serial_busy_o                  = (state != NORMAL);
endmodule

// File: tb/tb_id_issue_ctrl.sv
// Scoreboarded bench for id_issue_ctrl: a timestamp-based hazard model predicts each cycle's
// launch outputs, a negedge monitor compares them against the DUT.

module tb_id_issue_ctrl;
    localparam int DUAL_EN  = 1;
    localparam int LOAD_LAT = 2;

    typedef struct packed {
        logic v; logic [4:0] rd; logic we; logic [4:0] rj; logic rje;
        logic [4:0] rk; logic rke; logic ld; logic ser; logic br; logic md;
    } line_t;

    typedef struct packed {
        logic dbl; logic sgl; logic zro; logic l1v; logic l2v; logic busy;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    line_t l1 = '0, l2 = '0;
    logic  allowin = 1'b0, pempty = 1'b0, sdone = 1'b0, bflush = 1'b0, eflush = 1'b0;
    logic  dbl, sgl, zro, l1v, l2v, sbusy;

    exp_t expq[$];
    int   tests = 0, fails = 0;
    int   cyc = 0;
    int   mode = 0;          // 0 normal, 1 draining, 2 serial in flight
    int   ready_at[32];      // first cycle in which a register may be read again

    always #5 clk = ~clk;

    id_issue_ctrl #(.DUAL_EN(DUAL_EN), .LOAD_LAT(LOAD_LAT)) dut (
        .clk(clk), .rst(rst),
        .line1_valid_i(l1.v), .line2_valid_i(l2.v),
        .line1_rd_i(l1.rd), .line2_rd_i(l2.rd),
        .line1_rd_we_i(l1.we), .line2_rd_we_i(l2.we),
        .line1_rj_i(l1.rj), .line2_rj_i(l2.rj),
        .line1_rk_i(l1.rk), .line2_rk_i(l2.rk),
        .line1_rj_re_i(l1.rje), .line2_rj_re_i(l2.rje),
        .line1_rk_re_i(l1.rke), .line2_rk_re_i(l2.rke),
        .line1_is_load_i(l1.ld), .line2_is_load_i(l2.ld),
        .line1_is_serial_i(l1.ser), .line2_is_serial_i(l2.ser),
        .line1_is_branch_i(l1.br), .line2_is_branch_i(l2.br),
        .line1_is_muldiv_i(l1.md), .line2_is_muldiv_i(l2.md),
        .exe_allowin_i(allowin), .pipe_empty_i(pempty), .serial_done_i(sdone),
        .branch_flush_i(bflush), .excep_flush_i(eflush),
        .double_valid_inst_lunch_flag_o(dbl),
        .single_valid_inst_lunch_flag_o(sgl),
        .zero_valid_inst_lunch_flag_o(zro),
        .line1_launch_valid_o(l1v), .line2_launch_valid_o(l2v),
        .serial_busy_o(sbusy)
    );

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic line_t mk(input logic v, input int rd, input logic we, input int rj,
                                 input logic rje, input int rk, input logic rke,
                                 input logic ld, input logic ser, input logic br, input logic md);
        line_t x;
        x = '{v, rd[4:0], we, rj[4:0], rje, rk[4:0], rke, ld, ser, br, md};
        return x;
    endfunction

    function automatic line_t rnd_line(input logic v);
        line_t x;
        x.v   = v;
        x.rd  = 5'($urandom_range(0, 7));
        x.we  = ($urandom_range(0, 3) != 0);
        x.rj  = 5'($urandom_range(0, 7));
        x.rje = $urandom_range(0, 1);
        x.rk  = 5'($urandom_range(0, 7));
        x.rke = $urandom_range(0, 1);
        x.ld  = ($urandom_range(0, 3) == 0);
        x.ser = ($urandom_range(0, 15) == 0);
        x.br  = ($urandom_range(0, 7) == 0);
        x.md  = ($urandom_range(0, 3) == 0);
        return x;
    endfunction

    function automatic bit hz(input logic en, input logic [4:0] r);
        return en && r != 0 && cyc < ready_at[r];
    endfunction

    task automatic clr_sb();
        for (int i = 0; i < 32; i++) ready_at[i] = 0;
    endtask

    // Drive one cycle's inputs, predict its outputs and advance the model past the edge.
    task automatic step(input line_t a, input line_t b, input logic al, input logic pe,
                        input logic sd, input logic bf, input logic ef, input logic r);
        exp_t e;
        bit fl, h1, h2, ok1, pre1, p1, p2, raw, waw;
        @(posedge clk); #1;
        l1 = a; l2 = b; allowin = al; pempty = pe; sdone = sd;
        bflush = bf; eflush = ef; rst = r;
        cyc++;
        if (r) begin mode = 0; clr_sb(); end
        fl   = r || bf || ef;
        h1   = hz(a.rje, a.rj) || hz(a.rke, a.rk);
        h2   = hz(b.rje, b.rj) || hz(b.rke, b.rk);
        ok1  = (mode == 0) ? (!a.ser || pe) : (mode == 1) ? pe : 1'b0;
        pre1 = a.v && al && !fl && !h1;
        p1   = pre1 && ok1;
        raw  = a.we && a.rd != 0 && ((b.rje && b.rj == a.rd) || (b.rke && b.rk == a.rd));
        waw  = a.we && b.we && a.rd == b.rd && a.rd != 0;
        p2   = p1 && (DUAL_EN != 0) && b.v && !a.ser && !b.ser && !a.br &&
               !(a.md && b.md) && !(a.ld && b.ld) && !h2 && !raw && !waw;
        e.dbl = p1 && p2; e.sgl = p1 && !p2; e.zro = !p1;
        e.l1v = p1; e.l2v = p2; e.busy = (mode != 0);
        expq.push_back(e);
        if (p1 && a.ld && a.we && a.rd != 0) ready_at[a.rd] = cyc + LOAD_LAT + 1;
        if (p2 && b.ld && b.we && b.rd != 0) ready_at[b.rd] = cyc + LOAD_LAT + 1;
        if (fl) begin
            mode = 0; clr_sb();
        end else begin
            case (mode)
                0: if (p1 && a.ser) mode = 2;
                   else if (pre1 && a.ser && !pe) mode = 1;
                1: if (p1) mode = a.ser ? 2 : 0;
                default: if (sd) mode = 0;
            endcase
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("launch{dbl,sgl,zro,l1v,l2v,busy}", 8'({dbl, sgl, zro, l1v, l2v, sbusy}), 8'(e));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        line_t idle, a, b, s, n;
        clr_sb();
        idle = '0;
        #1;
        chk("rst_zero", 8'(zro), 8'd1);
        chk("rst_others", 8'({dbl, sgl, l1v, l2v, sbusy}), 8'd0);
        step(idle, idle, 1, 1, 0, 0, 0, 1);
        step(idle, idle, 1, 1, 0, 0, 0, 0);

        // independent ALU pair
        a = mk(1, 4, 1, 1, 1, 2, 1, 0, 0, 0, 0);
        b = mk(1, 8, 1, 5, 1, 6, 1, 0, 0, 0, 0);
        step(a, b, 1, 1, 0, 0, 0, 0); #1;
        chk("dual_dbl", 8'(dbl), 8'd1);
        chk("dual_valids", 8'({l1v, l2v}), 8'b11);
        // RAW from line1
        b = mk(1, 8, 1, 4, 1, 6, 1, 0, 0, 0, 0);
        step(a, b, 1, 1, 0, 0, 0, 0); #1;
        chk("raw_sgl", 8'(sgl), 8'd1);
        chk("raw_l2v", 8'(l2v), 8'd0);

        // load-use on r7
        step(mk(1, 7, 1, 0, 0, 0, 0, 1, 0, 0, 0), idle, 1, 1, 0, 0, 0, 0); #1;
        chk("ld_launch", 8'(sgl), 8'd1);
        a = mk(1, 3, 1, 7, 1, 0, 0, 0, 0, 0, 0);
        step(a, idle, 1, 1, 0, 0, 0, 0); #1; chk("ld_use_c1", 8'(zro), 8'd1);
        step(a, idle, 1, 1, 0, 0, 0, 0); #1; chk("ld_use_c2", 8'(zro), 8'd1);
        step(a, idle, 1, 1, 0, 0, 0, 0); #1; chk("ld_use_c3", 8'(sgl), 8'd1);

        // serial instruction drains, issues, then blocks until retired
        s = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        n = mk(1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(s, idle, 1, 0, 0, 0, 0, 0); #1; chk("ser_wait1", 8'(zro), 8'd1);
        step(s, idle, 1, 0, 0, 0, 0, 0); #1; chk("ser_drain_busy", 8'(sbusy), 8'd1);
        step(s, idle, 1, 0, 0, 0, 0, 0); #1; chk("ser_wait3", 8'({zro, sbusy}), 8'b11);
        step(s, idle, 1, 1, 0, 0, 0, 0); #1; chk("ser_issue", 8'(sgl), 8'd1);
        step(n, idle, 1, 1, 0, 0, 0, 0); #1; chk("ser_block", 8'({zro, sbusy}), 8'b11);
        step(n, idle, 1, 1, 1, 0, 0, 0); #1; chk("ser_done_cyc", 8'(zro), 8'd1);
        step(n, idle, 1, 1, 0, 0, 0, 0); #1; chk("ser_after", 8'({l1v, sbusy}), 8'b10);

        // flush clears the scoreboard
        step(mk(1, 7, 1, 0, 0, 0, 0, 1, 0, 0, 0), idle, 1, 1, 0, 0, 0, 0);
        step(mk(1, 9, 1, 0, 0, 0, 0, 1, 0, 0, 0), idle, 1, 1, 0, 0, 0, 0);
        a = mk(1, 11, 1, 7, 1, 0, 0, 0, 0, 0, 0);
        b = mk(1, 12, 1, 9, 1, 0, 0, 0, 0, 0, 0);
        step(a, b, 1, 1, 0, 1, 0, 0); #1; chk("flush_zero", 8'({zro, l1v, l2v}), 8'b100);
        step(a, b, 1, 1, 0, 0, 0, 0); #1; chk("flush_after_dbl", 8'({dbl, sbusy}), 8'b10);

        // asynchronous reset while a serial instruction is outstanding
        step(s, idle, 1, 1, 0, 0, 0, 0);
        step(n, idle, 1, 1, 0, 0, 0, 0); #1; chk("pre_rst_busy", 8'(sbusy), 8'd1);
        @(posedge clk); cyc++;
        #3 rst = 1'b1; mode = 0; clr_sb();
        #1;
        chk("async_rst", 8'({zro, l1v, l2v, sbusy}), 8'b1000);
        step(n, idle, 1, 1, 0, 0, 0, 1);
        step(idle, idle, 1, 1, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            logic v1;
            v1 = ($urandom_range(0, 9) != 0);
            step(rnd_line(v1), rnd_line(v1 ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0)),
                 $urandom_range(0, 4) != 0, $urandom_range(0, 1), $urandom_range(0, 5) == 0,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 199) == 0);
        end

        @(negedge clk); #1;
        tests++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending want 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/id_issue_ctrl.md
Name: id_issue_ctrl

Overview:
- Consumer end of the IF_ID dual-slot instruction queue, inside the ID stage.
- Each cycle it inspects the queue's two head entries and decides whether to launch two, one or zero instructions. It drives the queue's launch flags and the line valids toward EXE.
- Keeps a load-use scoreboard and a serialising-instruction FSM, so launch decisions are hazard-safe across cycles.

Parameters:
DUAL_EN, 1, 1 = dual launch allowed; 0 = line2 never launches
LOAD_LAT, 2, cycles a load's rd stays busy after launch (1..3)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
line1_valid_i / line2_valid_i  in  1  queue head entries valid
lineN_rd_i  in  5  destination register (N = 1,2)
lineN_rd_we_i  in  1  writes rd
lineN_rj_i / lineN_rk_i  in  5  source registers
lineN_rj_re_i / lineN_rk_re_i  in  1  source is read
lineN_is_load_i  in  1  load instruction
lineN_is_serial_i  in  1  CSR / ertn / idle / dbar / ibar
lineN_is_branch_i  in  1  branch or jump
lineN_is_muldiv_i  in  1  uses the single mul/div unit
exe_allowin_i  in  1  EXE accepts this cycle
pipe_empty_i  in  1  EXE..WB hold no valid instruction
serial_done_i  in  1  serial instruction retired (pulse)
branch_flush_i / excep_flush_i  in  1  flush
double_valid_inst_lunch_flag_o  out  1  two launched
single_valid_inst_lunch_flag_o  out  1  one launched (line1)
zero_valid_inst_lunch_flag_o  out  1  none launched
line1_launch_valid_o / line2_launch_valid_o  out  1  valid to EXE
serial_busy_o  out  1  FSM not in NORMAL

Behaviour:
- Launch outputs are combinational from the current inputs and registered state. Exactly one lunch flag is high in every cycle.
- line1_launch_valid_o = double | single; line2_launch_valid_o = double.
- Reset or any flush:
  - Forces zero=1 and both launch valids 0 in that cycle.
  - Next edge: FSM goes to NORMAL and all scoreboard counters clear.
  - Reset values: zero=1, all other outputs 0.
- Scoreboard:
  - 31 two-bit counters for r1..r31; r0 is never busy.
  - A source is hazardous if its re=1, its register is nonzero and its counter is nonzero.
  - Every edge, each nonzero counter decrements by 1.
  - A launched load with rd_we and rd≠0 loads LOAD_LAT into cnt[rd]. Load wins over decrement on the same register.
  - Both lines launching loads to the same rd is impossible (the WAW rule below).
- line1 launches (L1) iff all hold:
  - line1_valid_i and exe_allowin_i, no flush;
  - no line1 scoreboard hazard;
  - FSM allows it:
    - NORMAL: non-serial always; serial only if pipe_empty_i.
    - DRAIN: only if pipe_empty_i.
    - SERIAL: never.
- line2 launches iff all hold:
  - L1, DUAL_EN, line2_valid_i, ~line1_is_serial, ~line2_is_serial, ~line1_is_branch;
  - not both is_muldiv, not both is_load;
  - no line2 scoreboard hazard;
  - no RAW from line1: line1_rd_we, rd≠0 and rd equals an enabled line2 source;
  - no WAW: both rd_we with the same nonzero rd.
- FSM (2-bit):
  - NORMAL→DRAIN: line1 serial, valid, not launchable only because ~pipe_empty_i.
  - NORMAL/DRAIN→SERIAL: serial instruction launched (single).
  - SERIAL→NORMAL: serial_done_i.
  - Flush from any state → NORMAL. serial_done_i in NORMAL/DRAIN is ignored.
- While in DRAIN, line1 stays stalled until pipe_empty_i.
- ~exe_allowin_i forces zero and leaves scoreboard decrement unaffected.
- line2_valid_i with ~line1_valid_i is illegal and yields zero launch.

Test Plan:
- Two independent ALU ops (line1 rd=r4, line2 srcs r5/r6), allowin=1 -> double=1, both launch valids 1.
- Line1 writes r4, line2 reads rj=r4 -> single=1, line2_launch_valid_o=0.
- Line1 ld.w rd=r7 launches at cycle 0, next line1 reads r7, LOAD_LAT=2 -> zero at cycles 1 and 2, single at cycle 3.
- Line1 csrwr with pipe_empty_i=0 for 3 cycles -> zero, state DRAIN, serial_busy_o=1. Then pipe_empty_i=1 -> single. In SERIAL, valid instructions give zero until serial_done_i; next cycle a normal launch occurs.
- Loads busy on r7 and r9, then branch_flush_i pulse -> zero that cycle. Next cycle reads of r7/r9 launch double (scoreboard cleared), FSM NORMAL.
- rst asserted mid-SERIAL, asynchronously -> immediately zero=1, launch valids 0, serial_busy_o=0.
